pll_lock_supervisor: RTL

- Initiator side of the GPU PLL reset/lock handshake.
- Drives the PLL's active-high reset, watches its asynchronous locked output, and holds the downstream GPU reset until lock has been stable for a programmable time.
- On loss of lock, or on a software relock request, it re-asserts the GPU reset and re-pulses the PLL reset.
- Runs on the 50 MHz PLL reference clock, which is free-running and independent of lock.

---
 rtl/pll_lock_supervisor_if.sv | 35 +++
 rtl/pll_lock_supervisor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor_if.sv
// PLL lock-handshake bundle between the lock supervisor and the PLL / GPU side.
// master: the supervisor (drives PLL reset, GPU reset and status).
// slave : the PLL / GPU side (drives lock indication and relock requests).
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       gpu_rst;
    logic       pll_ready;
    logic [1:0] state;
    logic [7:0] loss_count;
    logic       timeout_seen;

    modport master (
        input  pll_locked,
        input  relock_req,
        output pll_rst,
        output gpu_rst,
        output pll_ready,
        output state,
        output loss_count,
        output timeout_seen
    );

    modport slave (
        output pll_locked,
        output relock_req,
        input  pll_rst,
        input  gpu_rst,
        input  pll_ready,
        input  state,
        input  loss_count,
        input  timeout_seen
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// GPU PLL lock supervisor: pulses the PLL reset, waits for a stable lock and
// only then releases the GPU reset. Lock loss or a software relock restarts it.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RESET_PLL | pll_rst held high for RST_PULSE_CYCLES refclk cycles
// WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT_CYCLES
// STABILIZE | lock must stay high for LOCK_STABLE_CYCLES consecutive cycles
// RUN       | gpu_rst released; lock is monitored for loss
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W               = 20
) (
    input  logic                    refclk_i,
    input  logic                    rst_i,
    pll_lock_supervisor_if.master   bus
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             locked_sync;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       loss_q;
    logic [7:0]       loss_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             pll_rst_q;
    logic             gpu_rst_q;
    logic             pll_ready_q;

    // pll_locked is asynchronous to refclk; only the second stage is used.
    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.pll_locked;
            sync2_q <= sync1_q;
        end
    end

    assign locked_sync = sync2_q;

    // Next-state, shared counter and status update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        loss_d    = loss_q;
        timeout_d = timeout_q;
        case (state_q)
            RESET_PLL: begin
                // relock_req is deliberately ignored: the pulse always runs to length.
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (bus.relock_req) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end else if (locked_sync) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = RESET_PLL;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABILIZE: begin
                // A drop here is an unsettled lock, not a loss; it is not counted.
                if (bus.relock_req) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end else if (!locked_sync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (!locked_sync || bus.relock_req) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                    if (!locked_sync && (loss_q != 8'hFF)) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; outputs decode state_d so they
    // change on the same edge as the state itself.
    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            loss_q      <= '0;
            timeout_q   <= 1'b0;
            pll_rst_q   <= 1'b1;
            gpu_rst_q   <= 1'b1;
            pll_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            timeout_q   <= timeout_d;
            pll_rst_q   <= (state_d == RESET_PLL);
            gpu_rst_q   <= (state_d != RUN);
            pll_ready_q <= (state_d == RUN);
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.gpu_rst      = gpu_rst_q;
    assign bus.pll_ready    = pll_ready_q;
    assign bus.state        = state_q;
    assign bus.loss_count   = loss_q;
    assign bus.timeout_seen = timeout_q;

endmodule
